// File: rtl/wtc_bin_to_bcd_pkg.sv
// ---------------------------------------------------------------------------
// wtc_bin_to_bcd_pkg
// Shared constants for the binary-to-BCD converter slice:
//   - FSM state encodings (IDLE / ADJ / SHIFT)
//   - BCD digit width
//   - double-dabble adjust threshold and addend
// ---------------------------------------------------------------------------
package wtc_bin_to_bcd_pkg;

    // FSM state encodings; kept as plain 2-bit constants so the encoding
    // stays stable for any legacy code that probes the state register.
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ADJ   = 2'd1;
    localparam logic [1:0] ST_SHIFT = 2'd2;

    // Width of one packed BCD digit.
    localparam int BCD_DIGIT_W = 4;

    // A digit of 5 or more becomes >= 10 after the next shift, so add 3
    // beforehand; the shift then carries the "ten" into the next digit.
    localparam logic [BCD_DIGIT_W-1:0] ADJ_THRESHOLD = 4'd5;
    localparam logic [BCD_DIGIT_W-1:0] ADJ_ADDEND    = 4'd3;

endpackage

// File: rtl/wtc_bin_to_bcd_digit_adj.sv
// ---------------------------------------------------------------------------
// wtc_bcd_digit_adj
// Combinational double-dabble adjust for a single BCD digit: adds 3 when the
// digit is 5 or more. No carry out; the result always fits in 4 bits because
// the largest legal input digit is 9 (9 + 3 = 12).
// Ports:
//   digit_in   in  4  BCD digit before adjust
//   digit_out  out 4  BCD digit after adjust
// ---------------------------------------------------------------------------
module wtc_bcd_digit_adj
    import wtc_bin_to_bcd_pkg::*;
(
    input  logic [BCD_DIGIT_W-1:0] digit_in,
    output logic [BCD_DIGIT_W-1:0] digit_out
);

    assign digit_out = (digit_in >= ADJ_THRESHOLD) ? (digit_in + ADJ_ADDEND)
                                                   : digit_in;

endmodule

// File: rtl/wtc_bin_to_bcd.sv
// ---------------------------------------------------------------------------
// wtc_bin_to_bcd
// Sequential double-dabble converter: unsigned binary in, packed BCD out.
// Each input bit costs two cycles (adjust, then shift), so a conversion takes
// 2*BIN_WIDTH clock edges from the accepting edge to the o_Done pulse.
//
// Parameters:
//   BIN_WIDTH  width of i_Binary and number of shift iterations
//   DIGITS     number of BCD output digits
//
// Ports:
//   i_Clk       in  1           clock, rising edge
//   i_Rst       in  1           synchronous active-high reset
//   i_Start     in  1           conversion request, honoured only when idle
//   i_Binary    in  BIN_WIDTH   value captured on the accepting edge
//   o_BCD       out 4*DIGITS    result, ones digit at [3:0]; holds last result
//   o_Done      out 1           one-cycle pulse when o_BCD updates
//   o_Busy      out 1           conversion in progress
//   o_Overflow  out 1           value needed more than DIGITS digits
//   o_Blank     out DIGITS      leading-zero blank flags
//
// Optional build macro: WTC_BCD_BLANK_EN
//   defined   -> o_Blank[k] (k>=1) is registered with o_BCD and set when digit
//                k and all higher digits are zero (cleared on overflow).
//   undefined -> o_Blank is tied to zero.
// ---------------------------------------------------------------------------
module wtc_bin_to_bcd
    import wtc_bin_to_bcd_pkg::*;
#(
    parameter int BIN_WIDTH = 8,
    parameter int DIGITS    = 3
) (
    input  logic                          i_Clk,
    input  logic                          i_Rst,
    input  logic                          i_Start,
    input  logic [BIN_WIDTH-1:0]          i_Binary,
    output logic [BCD_DIGIT_W*DIGITS-1:0] o_BCD,
    output logic                          o_Done,
    output logic                          o_Busy,
    output logic                          o_Overflow,
    output logic [DIGITS-1:0]             o_Blank
);

    localparam int BCD_W = BCD_DIGIT_W * DIGITS;
    localparam int CNT_W = $clog2(BIN_WIDTH + 1);

    logic [1:0]           state_reg;
    logic [BIN_WIDTH-1:0] shift_reg;
    logic [BCD_W-1:0]     scratch_reg;
    logic [CNT_W-1:0]     cnt_reg;
    logic                 ovf_sticky_reg;
    logic [BCD_W-1:0]     bcd_reg;
    logic                 done_reg;
    logic                 ovf_reg;

    logic [BCD_W-1:0]     scratch_adj;
    logic [BCD_W-1:0]     scratch_shifted;
    logic                 ovf_final;
    logic                 last_shift;

    // Per-digit adjust of the scratch register.
    generate
        for (genvar gi = 0; gi < DIGITS; gi++) begin : g_adj
            wtc_bcd_digit_adj u_adj (
                .digit_in  (scratch_reg[gi*BCD_DIGIT_W +: BCD_DIGIT_W]),
                .digit_out (scratch_adj[gi*BCD_DIGIT_W +: BCD_DIGIT_W])
            );
        end
    endgenerate

    // Scratch after one left shift of {scratch, shift}; the bit dropped off
    // the top digit is a multiple of 10^DIGITS, hence the overflow flag.
    assign scratch_shifted = {scratch_reg[BCD_W-2:0], shift_reg[BIN_WIDTH-1]};
    assign ovf_final       = ovf_sticky_reg | scratch_reg[BCD_W-1];
    assign last_shift      = (cnt_reg == CNT_W'(BIN_WIDTH - 1));

    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            state_reg      <= ST_IDLE;
            shift_reg      <= '0;
            scratch_reg    <= '0;
            cnt_reg        <= '0;
            ovf_sticky_reg <= 1'b0;
            bcd_reg        <= '0;
            done_reg       <= 1'b0;
            ovf_reg        <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    if (i_Start) begin
                        shift_reg      <= i_Binary;
                        scratch_reg    <= '0;
                        cnt_reg        <= '0;
                        ovf_sticky_reg <= 1'b0;
                        state_reg      <= ST_ADJ;
                    end
                end
                ST_ADJ: begin
                    scratch_reg <= scratch_adj;
                    state_reg   <= ST_SHIFT;
                end
                ST_SHIFT: begin
                    shift_reg      <= {shift_reg[BIN_WIDTH-2:0], 1'b0};
                    scratch_reg    <= scratch_shifted;
                    ovf_sticky_reg <= ovf_final;
                    cnt_reg        <= cnt_reg + 1'b1;
                    if (last_shift) begin
                        bcd_reg   <= scratch_shifted;
                        ovf_reg   <= ovf_final;
                        done_reg  <= 1'b1;
                        state_reg <= ST_IDLE;
                    end else begin
                        state_reg <= ST_ADJ;
                    end
                end
                default: begin
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

    assign o_BCD      = bcd_reg;
    assign o_Done     = done_reg;
    assign o_Busy     = (state_reg != ST_IDLE);
    assign o_Overflow = ovf_reg;

`ifdef WTC_BCD_BLANK_EN
    logic [DIGITS-1:0] blank_reg;
    logic [DIGITS-1:0] blank_next;

    // Digit 0 is never blanked so that a value of zero still shows "0".
    generate
        for (genvar gi = 0; gi < DIGITS; gi++) begin : g_blank
            if (gi == 0) begin : g_ones
                assign blank_next[gi] = 1'b0;
            end else begin : g_upper
                assign blank_next[gi] = ~ovf_final &&
                    (scratch_shifted[BCD_W-1:gi*BCD_DIGIT_W] == '0);
            end
        end
    endgenerate

    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            blank_reg <= '0;
        end else if ((state_reg == ST_SHIFT) && last_shift) begin
            blank_reg <= blank_next;
        end
    end

    assign o_Blank = blank_reg;
`else
    assign o_Blank = '0;
`endif

endmodule
